crc_msg_feeder: RTL and testbench

Upstream companion to the serial CRC encoder. Accepts a parallel message word over a valid/ready handshake and issues the one-cycle start pulse. It then serialises the word MSB-first, one bit per clock, onto the encoder's data input, waits for the encoder's done and captures its 16-bit remainder. The result is presented downstream through a second valid/ready handshake with an error flag if done never arrives.

---
 rtl/crc_pkg.sv | 22 ++
 rtl/piso_shift.sv | 44 ++++
 rtl/crc_msg_feeder.sv | 122 ++++++++++++
 tb/tb_crc_msg_feeder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_pkg
// Purpose  : Shared definitions for the CRC message feeder: FSM state
//            encoding and default message / remainder widths.
// Revision : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam int DEF_DATA_LENGTH = 32;
    localparam int DEF_CRC_WIDTH   = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        SHIFT     = 3'd2,
        WAIT_DONE = 3'd3,
        RESULT    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/piso_shift.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift
// Purpose  : Parallel-load, MSB-first shift register with a count of bits
//            shifted out and a flag raised once every bit has left.
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift #(
    parameter int DATA_LENGTH = 32,
    localparam int CNT_WIDTH = $clog2(DATA_LENGTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   shift,
    input  logic [DATA_LENGTH-1:0] load_data,
    output logic                   bit_out,
    output logic                   last
);

    logic [DATA_LENGTH-1:0] shreg;
    logic [CNT_WIDTH-1:0]   count;

    // Load restarts the bit count; each shift moves the next bit to the MSB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= load_data;
            count <= '0;
        end else if (shift) begin
            shreg <= {shreg[DATA_LENGTH-2:0], 1'b0};
            count <= count + CNT_WIDTH'(1);
        end
    end

    assign bit_out = shreg[DATA_LENGTH-1];
    // The bit is sampled into the output flop on the same edge it is shifted
    // away, so "all shifted" means every bit has already been handed out.
    assign last    = (count == CNT_WIDTH'(DATA_LENGTH));

endmodule
`default_nettype wire

// File: rtl/crc_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : crc_msg_feeder
// Purpose  : Accepts a message word, pulses the serial CRC encoder's start,
//            streams the word MSB-first, waits for done (with timeout) and
//            hands the captured remainder downstream via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module crc_msg_feeder
    import crc_pkg::*;
#(
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int CRC_WIDTH   = DEF_CRC_WIDTH,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_LENGTH-1:0] in_data,
    output logic                   crc_start,
    output logic                   crc_data,
    input  logic                   crc_done,
    input  logic [CRC_WIDTH-1:0]   crc_r,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CRC_WIDTH-1:0]   out_crc,
    output logic                   out_err
);

    localparam int TMO_WIDTH = $clog2(TIMEOUT + 1);

    state_t               state;
    logic [TMO_WIDTH-1:0] tmo_cnt;
    logic                 load;
    logic                 shift;
    logic                 bit_out;
    logic                 last;

    // Shifting starts in START so the first bit is already on crc_data in the
    // first SHIFT cycle; the output flop then always trails the register.
    assign load  = (state == IDLE) && in_valid && in_ready;
    assign shift = (state == START) || ((state == SHIFT) && !last);

    piso_shift #(
        .DATA_LENGTH(DATA_LENGTH)
    ) u_piso (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .shift     (shift),
        .load_data (in_data),
        .bit_out   (bit_out),
        .last      (last)
    );

    // Control FSM with registered handshake, encoder and result outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            in_ready  <= 1'b0;
            crc_start <= 1'b0;
            crc_data  <= 1'b0;
            out_valid <= 1'b0;
            out_crc   <= '0;
            out_err   <= 1'b0;
        end else begin
            crc_start <= 1'b0;
            crc_data  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready  <= 1'b0;
                        crc_start <= 1'b1;
                        state     <= START;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                START: begin
                    crc_data <= bit_out;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (last) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_DONE;
                    end else begin
                        crc_data <= bit_out;
                    end
                end
                WAIT_DONE: begin
                    // Done is checked first so it wins a tie with the timeout.
                    if (crc_done) begin
                        out_crc   <= crc_r;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= RESULT;
                    end else if (tmo_cnt == TMO_WIDTH'(TIMEOUT - 1)) begin
                        out_crc   <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_msg_feeder
// Purpose  : Self-checking bench for crc_msg_feeder: directed vector table,
//            hand-written reset-abort sequence and randomized messages checked
//            against a cycle-level expectation derived from the message rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_msg_feeder;

    localparam int DL  = 32;
    localparam int CW  = 16;
    localparam int TMO = 64;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DL-1:0] in_data = '0;
    logic          crc_start;
    logic          crc_data;
    logic          crc_done = 1'b0;
    logic [CW-1:0] crc_r = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_crc;
    logic          out_err;

    int n_cmp = 0;
    int n_err = 0;

    crc_msg_feeder #(
        .DATA_LENGTH(DL),
        .CRC_WIDTH  (CW),
        .TIMEOUT    (TMO)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .crc_start (crc_start),
        .crc_data  (crc_data),
        .crc_done  (crc_done),
        .crc_r     (crc_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc),
        .out_err   (out_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one message through the DUT with a stub encoder answering after
    // `delay` WAIT cycles (negative = never) and checks every cycle.
    // Caller must be at a negedge with the DUT idle and in_ready high.
    task automatic run_msg(input logic [DL-1:0] data, input int delay,
                           input logic [CW-1:0] r, input int bp, input logic spur);
        int          exp_rise;
        logic        exp_err;
        logic [CW-1:0] exp_crc;
        logic        exp_bit;
        exp_err  = !(delay >= 0 && delay < TMO);
        exp_crc  = exp_err ? '0 : r;
        exp_rise = exp_err ? TMO : delay + 1;

        in_valid = 1'b1;
        in_data  = data;
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = DL'($urandom);
        chk("start_pulse", 32'(crc_start), 32'd1);
        chk("start_data0", 32'(crc_data), 32'd0);
        chk("start_in_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < DL; i++) begin
            @(negedge clock);
            exp_bit = 1'((data >> (DL - 1 - i)) & 1);
            chk("shift_bit", 32'(crc_data), 32'(exp_bit));
            chk("shift_start_low", 32'(crc_start), 32'd0);
            if (i == 6) crc_done = 1'b0;
            if (spur && i == 5) begin
                crc_done = 1'b1;
                crc_r    = 16'hDEAD;
            end
        end

        for (int k = 0; k < exp_rise; k++) begin
            @(negedge clock);
            chk("wait_data0", 32'(crc_data), 32'd0);
            chk("wait_no_valid", 32'(out_valid), 32'd0);
            if (k == delay) begin
                crc_done = 1'b1;
                crc_r    = r;
            end
        end

        @(negedge clock);
        crc_done = 1'b0;
        crc_r    = CW'($urandom);
        chk("result_valid", 32'(out_valid), 32'd1);
        chk("result_crc", 32'(out_crc), 32'(exp_crc));
        chk("result_err", 32'(out_err), 32'(exp_err));

        for (int b = 0; b < bp; b++) begin
            in_valid = 1'b1;
            in_data  = DL'($urandom);
            @(negedge clock);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_crc", 32'(out_crc), 32'(exp_crc));
            chk("bp_err", 32'(out_err), 32'(exp_err));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_no_start", 32'(crc_start), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("consumed_valid", 32'(out_valid), 32'd0);
        chk("consumed_in_ready", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [DL-1:0] data;
        int            delay;
        logic [CW-1:0] r;
        int            bp;
        logic          spur;
        logic [CW-1:0] exp_crc;
        logic          exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'h03010203,    3, 16'hBEEF,  0, 1'b0, 16'hBEEF, 1'b0};
        vecs[1] = '{32'hA5A55A5A,   -1, 16'h1111,  0, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{32'h12345678,    0, 16'hCAFE, 20, 1'b0, 16'hCAFE, 1'b0};
        vecs[3] = '{32'hFFFFFFFF,    1, 16'h1234,  0, 1'b0, 16'h1234, 1'b0};
        vecs[4] = '{32'h00000001,    1, 16'h5678,  0, 1'b0, 16'h5678, 1'b0};
        vecs[5] = '{32'h80000001, TMO-1, 16'h0F0F, 2, 1'b1, 16'h0F0F, 1'b0};
        vecs[6] = '{32'h7FFFFFFE,  TMO, 16'hAAAA,  1, 1'b1, 16'h0000, 1'b1};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_start", 32'(crc_start), 32'd0);
        chk("rst_data", 32'(crc_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_crc", 32'(out_crc), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed table; the table's expected result must agree with the
        // rule-derived expectation used inside run_msg.
        for (int v = 0; v < 7; v++) begin
            chk("table_exp_err", 32'(vecs[v].exp_err),
                32'(!(vecs[v].delay >= 0 && vecs[v].delay < TMO)));
            run_msg(vecs[v].data, vecs[v].delay, vecs[v].r, vecs[v].bp, vecs[v].spur);
        end

        // Reset asserted while bit 10 is on the wire
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i <= 10; i++) @(negedge clock);
        chk("abort_bit10", 32'(crc_data), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_start", 32'(crc_start), 32'd0);
        chk("abort_data", 32'(crc_data), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("abort_idle_ready", 32'(in_ready), 32'd1);
        run_msg(32'hC3A50F96, 5, 16'h4242, 0, 1'b0);

        // Randomized messages
        for (int n = 0; n < 20; n++) begin
            int d;
            d = int'($urandom_range(0, TMO + 4));
            if (d > TMO + 2) d = -1;
            run_msg(DL'($urandom), d, CW'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
